// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit arbiter.
// State encoding and byte width used across the slice.
package uart_pkg;

    localparam int BYTE_W = 8;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        SEND = 2'b01,
        WAIT = 2'b10
    } state_t;

endpackage

// File: rtl/uart_tx_arb_if.sv
// Requester and transmitter signals of the arbiter.
// master drives requests and done ticks; slave is the arbiter.
interface uart_tx_arb_if
    import uart_pkg::*;
#(
    parameter int NREQ = 4
);
    localparam int IDW = $clog2(NREQ);

    logic [NREQ-1:0]        req;
    logic [BYTE_W*NREQ-1:0] din;
    logic [NREQ-1:0]        last;
    logic [NREQ-1:0]        ack;
    logic                   tx_start;
    logic [BYTE_W-1:0]      tx_din;
    logic                   tx_done_tick;
    logic                   busy;
    logic [IDW-1:0]         owner;
    logic                   locked;

    modport master (
        output req, din, last, tx_done_tick,
        input  ack, tx_start, tx_din, busy, owner, locked
    );

    modport slave (
        input  req, din, last, tx_done_tick,
        output ack, tx_start, tx_din, busy, owner, locked
    );

endinterface

// File: rtl/uart_tx_arb_rr_pick.sv
// Combinational round-robin selector.
// Scans ptr+1, ptr+2, ... modulo NREQ; ptr itself is checked last.
module rr_pick #(
    parameter int NREQ = 4,
    parameter int IDW  = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req_i,
    input  logic [IDW-1:0]  ptr_i,
    output logic            valid_o,
    output logic [IDW-1:0]  idx_o
);

    // Walk from the farthest slot to the nearest so the nearest wins.
    always_comb begin
        int          j;
        logic [IDW-1:0] j_idx;
        valid_o = 1'b0;
        idx_o   = ptr_i;
        j       = 0;
        j_idx   = '0;
        for (int k = NREQ; k >= 1; k--) begin
            j     = (int'(ptr_i) + k) % NREQ;
            j_idx = IDW'(j);
            if (req_i[j_idx]) begin
                valid_o = 1'b1;
                idx_o   = j_idx;
            end
        end
    end

endmodule

// File: rtl/uart_tx_arb.sv
// Round-robin arbiter sharing one UART transmitter among requesters.
// Supports packet locking with an idle timeout that releases the lock.
module uart_tx_arb
    import uart_pkg::*;
#(
    parameter int          NREQ    = 4,
    parameter logic [15:0] LOCK_TO = 16'd1000
) (
    input  logic          clk,
    input  logic          reset,
    uart_tx_arb_if.slave  bus
);

    localparam int IDW = $clog2(NREQ);
    localparam logic LOCK_EN = (LOCK_TO != 16'd0);

    state_t              state_q;
    logic [NREQ-1:0]     ack_q;
    logic                tx_start_q;
    logic [BYTE_W-1:0]   tx_din_q;
    logic                busy_q;
    logic [IDW-1:0]      owner_q;
    logic                locked_q;
    logic [15:0]         timer_q;

    logic [NREQ-1:0]     own_oh;
    logic [NREQ-1:0]     cand;
    logic                pick_v;
    logic [IDW-1:0]      pick_idx;
    logic [NREQ-1:0]     pick_oh;
    logic [BYTE_W-1:0]   din_sel;
    logic                last_sel;
    logic                lock_expire;

    // While locked only the owner may compete for the transmitter.
    always_comb begin
        own_oh = '0;
        for (int i = 0; i < NREQ; i++) begin
            own_oh[i] = (owner_q == IDW'(i));
        end
        cand = locked_q ? (bus.req & own_oh) : bus.req;
    end

    rr_pick #(
        .NREQ (NREQ),
        .IDW  (IDW)
    ) u_pick (
        .req_i   (cand),
        .ptr_i   (owner_q),
        .valid_o (pick_v),
        .idx_o   (pick_idx)
    );

    // Route the winner's byte and last flag to the latch point.
    always_comb begin
        pick_oh  = '0;
        din_sel  = '0;
        last_sel = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            if (pick_idx == IDW'(i)) begin
                pick_oh[i] = 1'b1;
                din_sel    = bus.din[BYTE_W*i +: BYTE_W];
                last_sel   = bus.last[i];
            end
        end
    end

    assign lock_expire = (timer_q == LOCK_TO - 16'd1);

    // Arbiter FSM with registered handshake and status outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            ack_q      <= '0;
            tx_start_q <= 1'b0;
            tx_din_q   <= '0;
            busy_q     <= 1'b0;
            owner_q    <= IDW'(NREQ - 1);
            locked_q   <= 1'b0;
            timer_q    <= '0;
        end else begin
            ack_q      <= '0;
            tx_start_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (pick_v) begin
                        tx_din_q   <= din_sel;
                        owner_q    <= pick_idx;
                        locked_q   <= LOCK_EN && !last_sel;
                        timer_q    <= '0;
                        ack_q      <= pick_oh;
                        tx_start_q <= 1'b1;
                        busy_q     <= 1'b1;
                        state_q    <= SEND;
                    end else if (locked_q) begin
                        if (lock_expire) begin
                            locked_q <= 1'b0;
                            timer_q  <= '0;
                        end else begin
                            timer_q <= timer_q + 16'd1;
                        end
                    end
                end
                SEND: begin
                    state_q <= WAIT;
                end
                WAIT: begin
                    if (bus.tx_done_tick) begin
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign bus.ack      = ack_q;
    assign bus.tx_start = tx_start_q;
    assign bus.tx_din   = tx_din_q;
    assign bus.busy     = busy_q;
    assign bus.owner    = owner_q;
    assign bus.locked   = locked_q;

endmodule

// File: tb/tb_uart_tx_arb.sv
// Bench for uart_tx_arb: table of arbitration rounds plus lock,
// timeout, reset and spurious-tick sequences, checked by a scoreboard.
module tb_uart_tx_arb;
    import uart_pkg::*;

    localparam int N = 4;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    uart_tx_arb_if #(.NREQ(N)) bus();

    uart_tx_arb #(
        .NREQ    (N),
        .LOCK_TO (16'd8)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int tx_cnt = 0;
    bit spur = 1'b0;

    logic [8:0] pend [N][$];
    logic [9:0] exp_q [$];

    typedef struct {
        logic [3:0] mask;
        logic [7:0] base;
        int         n;
        logic [7:0] ord;
    } vec_t;

    vec_t tbl [6];

    function automatic void chk(string name, bit ok, int act, int expv);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL %s: got %0h want %0h", name, act, expv);
        end
    endfunction

    function automatic bit pend_empty();
        bit e = 1'b1;
        for (int i = 0; i < N; i++) begin
            if (pend[i].size() != 0) e = 1'b0;
        end
        return e;
    endfunction

    // Requesters, transmitter model and grant monitor.
    initial begin
        logic [9:0] e;
        logic [N-1:0] oh;
        bus.req = '0;
        bus.din = '0;
        bus.last = '0;
        bus.tx_done_tick = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            bus.tx_done_tick = 1'b0;
            if (reset) begin
                tx_cnt = 0;
            end else begin
                if (tx_cnt > 0) begin
                    tx_cnt--;
                    if (tx_cnt == 0) bus.tx_done_tick = 1'b1;
                end
                if (bus.tx_start) tx_cnt = 20;
            end
            if (spur) begin
                bus.tx_done_tick = 1'b1;
                spur = 1'b0;
            end
            for (int i = 0; i < N; i++) begin
                if (bus.ack[i] && pend[i].size() > 0)
                    void'(pend[i].pop_front());
                if (pend[i].size() > 0) begin
                    bus.req[i] = 1'b1;
                    bus.din[8*i +: 8] = pend[i][0][7:0];
                    bus.last[i] = pend[i][0][8];
                end else begin
                    bus.req[i] = 1'b0;
                end
            end
            @(negedge clk);
            if (bus.tx_start || bus.ack != '0) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_grant", 1'b0, bus.tx_din, 0);
                end else begin
                    e = exp_q.pop_front();
                    oh = '0;
                    oh[e[9:8]] = 1'b1;
                    chk("ack_start", bus.tx_start && bus.ack == oh,
                        {bus.tx_start, bus.ack}, {1'b1, oh});
                    chk("grant_byte", bus.tx_din == e[7:0], bus.tx_din, e[7:0]);
                    chk("grant_owner", bus.owner == e[9:8], bus.owner, e[9:8]);
                end
            end
        end
    end

    task automatic wait_idle(string name);
        int n = 0;
        bit done = 1'b0;
        while (!done && n < 600) begin
            @(negedge clk);
            n++;
            done = exp_q.size() == 0 && pend_empty() &&
                   !bus.busy && !bus.tx_start;
        end
        chk({name, "_idle"}, done, n, 600);
    endtask

    task automatic wait_start(string name, output int c);
        int n = 0;
        bit seen = 1'b0;
        while (!seen && n < 100) begin
            @(negedge clk);
            n++;
            seen = bus.tx_start;
        end
        c = cyc;
        chk({name, "_start"}, seen, n, 100);
    endtask

    task automatic wait_tick(string name);
        int n = 0;
        bit seen = 1'b0;
        while (!seen && n < 100) begin
            @(negedge clk);
            n++;
            seen = bus.tx_done_tick;
        end
        chk({name, "_tick"}, seen, n, 100);
    endtask

    initial begin
        vec_t v;
        logic [7:0] o;
        logic [1:0] idx;
        int st [4];
        logic [3:0] lk;
        bit ok;

        tbl[0] = '{4'b1111, 8'hA0, 4, 8'hE4};
        tbl[1] = '{4'b0100, 8'h53, 1, 8'h02};
        tbl[2] = '{4'b1011, 8'hC0, 3, 8'h13};
        tbl[3] = '{4'b0101, 8'h10, 2, 8'h02};
        tbl[4] = '{4'b0001, 8'h20, 1, 8'h00};
        tbl[5] = '{4'b1110, 8'h30, 3, 8'h39};

        repeat (3) @(negedge clk);
        chk("rst_busy", bus.busy == 1'b0, bus.busy, 0);
        chk("rst_locked", bus.locked == 1'b0, bus.locked, 0);
        chk("rst_out", bus.ack == '0 && !bus.tx_start && bus.tx_din == 8'h00,
            {bus.ack, bus.tx_start, bus.tx_din}, 0);
        chk("rst_owner", bus.owner == 2'd3, bus.owner, 3);
        reset = 1'b0;
        @(negedge clk);

        for (int r = 0; r < 6; r++) begin
            v = tbl[r];
            o = v.ord;
            for (int i = 0; i < N; i++) begin
                if (v.mask[i]) pend[i].push_back({1'b1, v.base + 8'(i)});
            end
            for (int k = 0; k < v.n; k++) begin
                idx = o[2*k +: 2];
                exp_q.push_back({idx, v.base + 8'(idx)});
            end
            wait_idle("tbl");
            idx = o[2*(v.n-1) +: 2];
            chk("tbl_owner", bus.owner == idx, bus.owner, idx);
            chk("tbl_unlocked", bus.locked == 1'b0, bus.locked, 0);
        end

        pend[1].push_back({1'b0, 8'hB0});
        pend[1].push_back({1'b0, 8'hB1});
        pend[1].push_back({1'b1, 8'hB2});
        pend[3].push_back({1'b1, 8'h33});
        exp_q.push_back({2'd1, 8'hB0});
        exp_q.push_back({2'd1, 8'hB1});
        exp_q.push_back({2'd1, 8'hB2});
        exp_q.push_back({2'd3, 8'h33});
        lk = 4'b0011;
        for (int k = 0; k < 4; k++) begin
            wait_start("pkt", st[k]);
            chk("pkt_locked", bus.locked == lk[k], bus.locked, lk[k]);
            if (k > 0)
                chk("pkt_gap", st[k] - st[k-1] == 22, st[k] - st[k-1], 22);
        end
        wait_idle("pkt");
        chk("pkt_owner", bus.owner == 2'd3, bus.owner, 3);

        pend[0].push_back({1'b0, 8'h40});
        pend[1].push_back({1'b1, 8'h41});
        exp_q.push_back({2'd0, 8'h40});
        exp_q.push_back({2'd1, 8'h41});
        wait_start("to", st[0]);
        chk("to_locked", bus.locked == 1'b1, bus.locked, 1);
        wait_tick("to");
        ok = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            if (!bus.locked || bus.tx_start) ok = 1'b0;
        end
        chk("to_hold8", ok, bus.locked, 1);
        @(negedge clk);
        chk("to_release", !bus.locked && !bus.tx_start,
            {bus.locked, bus.tx_start}, 0);
        @(negedge clk);
        chk("to_grant1", bus.tx_start && bus.ack == 4'b0010,
            {bus.tx_start, bus.ack}, 5'b10010);
        wait_idle("to");

        pend[2].push_back({1'b1, 8'h55});
        exp_q.push_back({2'd2, 8'h55});
        @(negedge clk);
        chk("lat_req", bus.req == 4'b0100 && !bus.tx_start,
            {bus.req, bus.tx_start}, 5'b01000);
        @(negedge clk);
        chk("lat_start", bus.tx_start && bus.ack == 4'b0100 && bus.busy,
            {bus.tx_start, bus.ack, bus.busy}, 6'b101001);
        wait_tick("lat");
        chk("lat_busy_tick", bus.busy == 1'b1, bus.busy, 1);
        @(negedge clk);
        chk("lat_busy_drop", bus.busy == 1'b0, bus.busy, 0);
        chk("lat_hold", bus.tx_din == 8'h55 && bus.owner == 2'd2,
            {bus.tx_din, bus.owner}, {8'h55, 2'd2});
        wait_idle("lat");

        spur = 1'b1;
        ok = 1'b1;
        repeat (4) begin
            @(negedge clk);
            if (bus.busy || bus.tx_start) ok = 1'b0;
        end
        chk("spur_idle", ok, bus.busy, 0);
        pend[3].push_back({1'b1, 8'h99});
        exp_q.push_back({2'd3, 8'h99});
        @(negedge clk);
        spur = 1'b1;
        @(negedge clk);
        chk("spur_send", bus.tx_start && bus.tx_done_tick,
            {bus.tx_start, bus.tx_done_tick}, 2'b11);
        ok = 1'b1;
        repeat (15) begin
            @(negedge clk);
            if (!bus.busy) ok = 1'b0;
        end
        chk("spur_wait_busy", ok, bus.busy, 1);
        wait_idle("spur");
        chk("spur_owner", bus.owner == 2'd3, bus.owner, 3);

        pend[2].push_back({1'b0, 8'h77});
        exp_q.push_back({2'd2, 8'h77});
        wait_start("rst", st[0]);
        chk("rst_pre_locked", bus.locked == 1'b1, bus.locked, 1);
        repeat (5) @(negedge clk);
        reset = 1'b1;
        #1;
        chk("mid_rst_clear", !bus.busy && !bus.locked && bus.tx_din == 8'h00,
            {bus.busy, bus.locked, bus.tx_din}, 0);
        chk("mid_rst_owner", bus.owner == 2'd3 && bus.ack == '0,
            {bus.owner, bus.ack}, 6'b110000);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        pend[0].push_back({1'b1, 8'h10});
        pend[1].push_back({1'b1, 8'h11});
        exp_q.push_back({2'd0, 8'h10});
        exp_q.push_back({2'd1, 8'h11});
        wait_idle("post_rst");
        chk("post_rst_owner", bus.owner == 2'd1, bus.owner, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
